// File: rtl/sd_pkg.sv
// Shared constants and read-side FSM states for the SD DMA sink.
package sd_pkg;

    localparam int unsigned SD_BLOCK_BYTES = 512;
    localparam int unsigned SD_WORD_W      = 32;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHIFT
    } rd_state_t;

endpackage

// File: rtl/sd_dma_bank_ram.sv
// Simple dual-port RAM holding both ping-pong banks (bank is the address MSB).
// Synchronous write, registered read with one cycle of latency.
module sd_dma_bank_ram
    import sd_pkg::*;
#(
    parameter int unsigned WORDS = 128
) (
    input  logic                             i_clk,
    input  logic                             i_we,
    input  logic [$clog2(2*WORDS)-1:0]       i_waddr,
    input  logic [SD_WORD_W-1:0]             i_wdata,
    input  logic                             i_re,
    input  logic [$clog2(2*WORDS)-1:0]       i_raddr,
    output logic [SD_WORD_W-1:0]             o_rdata
);

    logic [SD_WORD_W-1:0] r_mem [2*WORDS];
    logic [SD_WORD_W-1:0] r_rdata;

    // Read data only updates on a read request so the presented word holds during stalls.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sd_dma_sink.sv
// Wishbone classic write sink into a two-bank block buffer, replayed as a byte stream.
// Optional macro SD_DMA_SINK_BYTESWAP_EN: emit each word LSB-first instead of MSB-first.
module sd_dma_sink
    import sd_pkg::*;
#(
    parameter int unsigned BLOCK_BYTES = SD_BLOCK_BYTES,
    parameter int unsigned COUNT_W     = 16
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [31:0]        wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    output logic [31:0]        wb_dat_o,
    input  logic [3:0]         wb_sel_i,
    input  logic               wb_we_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    output logic               wb_ack_o,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic [COUNT_W-1:0] block_count
);

    localparam int unsigned WORDS = BLOCK_BYTES / 4;
    localparam int unsigned IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    logic               r_ack;
    logic [1:0]         r_full;
    logic               r_wr_bank;
    logic [IDX_W-1:0]   r_wr_idx;
    rd_state_t          r_state;
    rd_state_t          w_next;
    logic               r_rd_bank;
    logic [IDX_W-1:0]   r_rd_idx;
    logic [1:0]         r_byte;
    logic [COUNT_W-1:0] r_block_count;

    logic               w_accept;
    logic               w_wr;
    logic               w_wr_done;
    logic               w_fire;
    logic               w_word_end;
    logic               w_blk_end;
    logic [1:0]         w_full_set;
    logic [1:0]         w_full_clr;
    logic [31:0]        w_rdata;
    logic [1:0]         w_lane;
    logic [7:0]         w_byte;
    logic               w_unused;

    assign w_unused   = ^{wb_adr_i, wb_sel_i};

    // No new request is evaluated while ack is high, so every transfer spans two cycles.
    assign w_accept   = wb_cyc_i & wb_stb_i & ~r_ack & ~r_full[r_wr_bank];
    assign w_wr       = w_accept & wb_we_i;
    assign w_wr_done  = w_wr & (r_wr_idx == LAST_IDX);
    assign w_full_set = w_wr_done ? (2'b01 << r_wr_bank) : 2'b00;

    assign w_fire     = (r_state == SHIFT) & out_ready;
    assign w_word_end = w_fire & (r_byte == 2'd3);
    assign w_blk_end  = w_word_end & (r_rd_idx == LAST_IDX);
    assign w_full_clr = w_blk_end ? (2'b01 << r_rd_bank) : 2'b00;

    sd_dma_bank_ram #(.WORDS(WORDS)) u_ram (
        .i_clk   (wb_clk_i),
        .i_we    (w_wr),
        .i_waddr ({r_wr_bank, r_wr_idx}),
        .i_wdata (wb_dat_i),
        .i_re    (r_state == FETCH),
        .i_raddr ({r_rd_bank, r_rd_idx}),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (r_full[r_rd_bank]) w_next = FETCH;
            FETCH:   w_next = SHIFT;
            SHIFT: begin
                if (w_blk_end)       w_next = IDLE;
                else if (w_word_end) w_next = FETCH;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack         <= 1'b0;
            r_full        <= 2'b00;
            r_wr_bank     <= 1'b0;
            r_wr_idx      <= '0;
            r_state       <= IDLE;
            r_rd_bank     <= 1'b0;
            r_rd_idx      <= '0;
            r_byte        <= 2'd0;
            r_block_count <= '0;
        end else begin
            r_ack   <= w_accept;
            r_full  <= (r_full | w_full_set) & ~w_full_clr;
            r_state <= w_next;
            if (w_wr)       r_wr_idx  <= r_wr_idx + 1'b1;
            if (w_wr_done)  r_wr_bank <= ~r_wr_bank;
            if (w_fire)     r_byte    <= r_byte + 2'd1;
            if (w_word_end) r_rd_idx  <= r_rd_idx + 1'b1;
            if (w_blk_end) begin
                r_rd_bank     <= ~r_rd_bank;
                r_block_count <= r_block_count + 1'b1;
            end
        end
    end

`ifdef SD_DMA_SINK_BYTESWAP_EN
    assign w_lane = r_byte;
`else
    assign w_lane = ~r_byte;
`endif

    always_comb begin
        w_byte = 8'h00;
        case (w_lane)
            2'd0: w_byte = w_rdata[7:0];
            2'd1: w_byte = w_rdata[15:8];
            2'd2: w_byte = w_rdata[23:16];
            2'd3: w_byte = w_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
    end

    assign wb_ack_o    = r_ack;
    assign wb_dat_o    = '0;
    assign out_valid   = (r_state == SHIFT);
    assign out_data    = out_valid ? w_byte : 8'h00;
    assign out_last    = out_valid & (r_byte == 2'd3) & (r_rd_idx == LAST_IDX);
    assign block_count = r_block_count;

endmodule

// File: tb/tb_sd_dma_sink.sv
// Directed bench for sd_dma_sink: a byte-queue model checks every streamed byte,
// plus explicit checks of reset, latency, stall and read-cycle behaviour.
module tb_sd_dma_sink;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] adr = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic        we = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        ack;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic [15:0] block_count;

    always #5 clk = ~clk;

    sd_dma_sink #(.BLOCK_BYTES(512), .COUNT_W(16)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wb_adr_i    (adr),
        .wb_dat_i    (dat_i),
        .wb_dat_o    (dat_o),
        .wb_sel_i    (4'hF),
        .wb_we_i     (we),
        .wb_cyc_i    (cyc),
        .wb_stb_i    (stb),
        .wb_ack_o    (ack),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .block_count (block_count)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_wr  = 0;
    int unsigned out_cnt = 0;
    logic [7:0]  exp_q[$];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic        prev_last = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] word_k(input int k);
        logic [7:0] b0, b1, b2, b3;
        b0 = 8'(4*k);
        b1 = 8'(4*k + 1);
        b2 = 8'(4*k + 2);
        b3 = 8'(4*k + 3);
        return {b0, b1, b2, b3};
    endfunction

    task automatic push_word(input logic [31:0] w);
`ifdef SD_DMA_SINK_BYTESWAP_EN
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[31:24]);
`else
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
`endif
    endtask

    task automatic wb_xfer(input logic wr, input logic [31:0] d);
        int t;
        t = 0;
        cyc = 1'b1; stb = 1'b1; we = wr; dat_i = d; adr = adr + 32'd4;
        do begin
            @(posedge clk); #1;
            t++;
        end while (!ack && t < 5000);
        chk("ack_seen", ack, 1);
        if (wr) begin
            push_word(d);
            n_wr++;
        end else begin
            chk("read_dat_o", dat_o, 0);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ack", ack, 0);
        chk("rst_dat_o", dat_o, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_block_count", block_count, 0);
        rst = 1'b0;
        exp_q.delete();
        n_wr = 0;
    endtask

    task automatic wait_count(input logic [15:0] n);
        int t;
        t = 0;
        while (block_count !== n && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("block_count", block_count, n);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    // Called right after the acked write that completes a block.
    task automatic first_out_check(input logic [7:0] b);
        @(posedge clk); #1;
        chk("fetch_gap_valid", out_valid, 0);
        @(posedge clk); #1;
        chk("first_valid", out_valid, 1);
        chk("first_byte", out_data, b);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            out_cnt    = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
                chk("hold_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                chk("byte_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("out_data", out_data, exp_q.pop_front());
                chk("out_last", out_last, (out_cnt % 512) == 511);
                out_cnt++;
            end
            if (|(dut.w_full_set & dut.w_full_clr))
                chk("set_clr_same_bank", dut.w_full_set & dut.w_full_clr, 0);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    initial begin
        // Reset and one block with the consumer always ready.
        do_reset();
        for (int k = 0; k < 127; k++) wb_xfer(1'b1, word_k(k));
        chk("no_output_before_full", out_valid, 0);
        wb_xfer(1'b1, word_k(127));
`ifdef SD_DMA_SINK_BYTESWAP_EN
        first_out_check(8'h03);
`else
        first_out_check(8'h00);
`endif
        wait_count(16'd1);

        // Three blocks with the consumer stalled: both banks fill, then writes stall.
        do_reset();
        out_ready = 1'b0;
        fork
            for (int k = 0; k < 384; k++) wb_xfer(1'b1, word_k(k));
            begin
                repeat (700) @(posedge clk);
                #1;
                chk("stall_writes_done", n_wr, 256);
                chk("stall_ack_low", ack, 0);
                chk("stall_valid", out_valid, 1);
                chk("stall_first_byte", out_data, exp_q[0]);
                out_ready = 1'b1;
            end
        join
        wait_count(16'd3);

        // Consumer ready toggling at random.
        do_reset();
        fork
            for (int k = 0; k < 128; k++) wb_xfer(1'b1, word_k(k) ^ 32'h3C3C3C3C);
            for (int c = 0; c < 3000; c++) begin
                @(posedge clk); #1;
                out_ready = 1'($urandom_range(0, 1));
            end
        join
        out_ready = 1'b1;
        wait_count(16'd1);

        // Reset mid-block discards the partial bank.
        do_reset();
        for (int k = 0; k < 60; k++) wb_xfer(1'b1, word_k(k) + 32'h50505050);
        do_reset();
        for (int k = 0; k < 128; k++) wb_xfer(1'b1, word_k(k) ^ 32'hA5A5A5A5);
`ifdef SD_DMA_SINK_BYTESWAP_EN
        first_out_check(8'hA6);
`else
        first_out_check(8'hA5);
`endif
        wait_count(16'd1);

        // Read cycle mid-block must not advance the write index.
        do_reset();
        wb_xfer(1'b1, 32'h11223344);
        for (int k = 1; k < 10; k++) wb_xfer(1'b1, word_k(k));
        wb_xfer(1'b0, 32'hFFFFFFFF);
        @(posedge clk); #1;
        chk("read_ack_one_cycle", ack, 0);
        for (int k = 10; k < 127; k++) wb_xfer(1'b1, word_k(k));
        chk("read_no_early_full", out_valid, 0);
        wb_xfer(1'b1, word_k(127));
`ifdef SD_DMA_SINK_BYTESWAP_EN
        first_out_check(8'h44);
`else
        first_out_check(8'h11);
`endif
        wait_count(16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
